// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffer pipeline register with registered in_ready and valid/ready on both sides.
// Optional macro PIPE_SKID_OCCUPANCY_EN adds occupancy and sticky overflow_err outputs.
module pipe_skid_reg #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             softReset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_OCCUPANCY_EN
   ,
   output logic [1:0]       occupancy,
   output logic             overflow_err
`endif
);

   // State encoding is {skid_v, main_v}; 2'b10 is unreachable.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_HALF  = 2'b01,
      ST_FULL  = 2'b11
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_in_ready;
   logic [WIDTH-1:0] r_main_data;
   logic [WIDTH-1:0] r_skid_data;

   logic w_accept;
   logic w_deliver;
   logic w_load_main_in;
   logic w_load_main_skid;
   logic w_load_skid;
   logic w_nxt_main_v;
   logic w_nxt_skid_v;

   assign w_accept   = in_valid & r_in_ready;
   assign w_deliver  = (r_state != ST_EMPTY) & out_ready;

   assign in_ready   = r_in_ready;
   assign out_valid  = (r_state != ST_EMPTY);
   assign out_data   = r_main_data;

   assign w_nxt_main_v = (w_state_nxt != ST_EMPTY);
   assign w_nxt_skid_v = (w_state_nxt == ST_FULL);

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch can be inferred.
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      unique case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt    = ST_HALF;
               w_load_main_in = 1'b1;
            end
         end
         ST_HALF: begin
            if (w_accept && w_deliver) begin
               w_load_main_in = 1'b1;
            end else if (w_accept) begin
               w_state_nxt = ST_FULL;
               w_load_skid = 1'b1;
            end else if (w_deliver) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_deliver) begin
               w_state_nxt      = ST_HALF;
               w_load_main_skid = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      // Flush squashes any same-cycle transfer; data registers keep their contents.
      if (softReset) begin
         w_state_nxt      = ST_EMPTY;
         w_load_main_in   = 1'b0;
         w_load_main_skid = 1'b0;
         w_load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         // NOTE: payload registers are cleared too, so out_data reads zero right after reset.
         r_main_data <= '0;
         r_skid_data <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= ~w_nxt_skid_v;
         if (w_load_main_in) begin
            r_main_data <= in_data;
         end else if (w_load_main_skid) begin
            r_main_data <= r_skid_data;
         end
         if (w_load_skid) begin
            r_skid_data <= in_data;
         end
      end
   end

`ifdef PIPE_SKID_OCCUPANCY_EN
   logic [1:0]       r_occupancy;
   logic             r_overflow_err;
   logic [WIDTH-1:0] r_prev_in_data;

   assign occupancy    = r_occupancy;
   assign overflow_err = r_overflow_err;

   // Upstream must hold in_data while stalled; a change during a stall is latched as an error.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_occupancy    <= 2'd0;
         r_overflow_err <= 1'b0;
         r_prev_in_data <= '0;
      end else begin
         r_occupancy    <= {1'b0, w_nxt_main_v} + {1'b0, w_nxt_skid_v};
         r_prev_in_data <= in_data;
         if (in_valid && !r_in_ready && (in_data != r_prev_in_data)) begin
            r_overflow_err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios then random traffic against a queue model.
module tb_pipe_skid_reg;

   localparam int W = 9;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         softReset = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
`ifdef PIPE_SKID_OCCUPANCY_EN
   logic [1:0]   occupancy;
   logic         overflow_err;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   pipe_skid_reg #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .softReset (softReset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef PIPE_SKID_OCCUPANCY_EN
      ,
      .occupancy    (occupancy),
      .overflow_err (overflow_err)
`endif
   );

   // Reference model: a FIFO of at most two words plus the last word shown at the output.
   logic [W-1:0] mq[$];
   logic [W-1:0] m_main = '0;
   logic [W-1:0] m_prev = '0;
   bit           m_ovf  = 1'b0;

   task automatic model_step();
      bit acc;
      bit del;
      if (reset) begin
         mq.delete();
         m_main = '0;
         m_prev = '0;
         m_ovf  = 1'b0;
      end else begin
         acc = in_valid && (mq.size() < 2);
         del = (mq.size() > 0) && out_ready;
         if (in_valid && (mq.size() == 2) && (in_data != m_prev)) m_ovf = 1'b1;
         m_prev = in_data;
         if (softReset) begin
            mq.delete();
         end else begin
            if (del) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
         end
         if (mq.size() > 0) m_main = mq[0];
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
      check({tag, ".out_data"},  {23'd0, out_data},  {23'd0, m_main});
      check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, (mq.size() < 2)});
`ifdef PIPE_SKID_OCCUPANCY_EN
      check({tag, ".occupancy"},    {30'd0, occupancy},    32'(mq.size()));
      check({tag, ".overflow_err"}, {31'd0, overflow_err}, {31'd0, m_ovf});
`endif
   endtask

   // One clock: model consumes the inputs present at the edge, outputs are sampled 1ns later.
   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Hard reset, then idle.
      reset = 1'b1;
      model_step();
      @(posedge clk);
      #1;
      model_step();
      @(posedge clk);
      #1;
      check_all("reset");
      check("reset.out_data0", {23'd0, out_data}, 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) tick("idle");

      // Back-to-back stream at full rate.
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         in_valid = 1'b1;
         in_data  = W'(i);
         tick("stream");
         check("stream.word", {23'd0, out_data}, 32'(i));
         check("stream.ready", {31'd0, in_ready}, 32'd1);
      end
      in_valid = 1'b0;
      tick("stream_drain");
      tick("stream_idle");

      // Fill to FULL while downstream stalls.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 9'h0AA;
      tick("fill_a");
      in_data   = 9'h155;
      tick("fill_b");
      check("full.in_ready", {31'd0, in_ready}, 32'd0);
      check("full.out_data", {23'd0, out_data}, 32'h0AA);
      // Upstream holds its word while stalled; nothing should change.
      tick("full_hold");
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick("drain_a");
      check("drain.second", {23'd0, out_data}, 32'h155);
      check("drain.ready",  {31'd0, in_ready}, 32'd1);
      tick("drain_b");
      tick("drain_idle");

      // Refill, then flush with a conflicting input word present.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 9'h0AA;
      tick("refill_a");
      in_data   = 9'h155;
      tick("refill_b");
      softReset = 1'b1;
      in_data   = 9'h1FF;
      tick("flush");
      check("flush.out_valid", {31'd0, out_valid}, 32'd0);
      check("flush.in_ready",  {31'd0, in_ready},  32'd1);
      softReset = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick("post_flush");
         check("post_flush.no_1ff", {31'd0, (out_valid && out_data == 9'h1FF)}, 32'd0);
      end

      // Hard reset and flush together while HALF.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 9'h123;
      tick("half_123");
      in_valid  = 1'b0;
      reset     = 1'b1;
      softReset = 1'b1;
      tick("both_resets");
      check("both.out_data", {23'd0, out_data}, 32'h0);
      reset     = 1'b0;
      softReset = 1'b0;
      tick("after_both");

      // Random traffic; upstream usually holds its word while stalled.
      for (int i = 0; i < 400; i++) begin
         if (!(in_valid && !in_ready) || ($urandom_range(0, 7) == 0)) begin
            in_data  = W'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         softReset = ($urandom_range(0, 24) == 0);
         reset     = ($urandom_range(0, 59) == 0);
         tick("rand");
      end
      reset     = 1'b0;
      softReset = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick("final_a");
      tick("final_b");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
